// File: rtl/rtc_alarm_if.sv
// Register-side bundle for the RTC: time/alarm strobes in, time/status out.
// Latency: wiring only, no storage.
// Backpressure: none; strobes are always taken or rejected via cfg_err.
interface rtc_alarm_if;
  // control and configuration, driven by the register side
  logic       run;
  logic       load;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic [5:0] set_seconds;
  logic       alarm_wr;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       alarm_en;
  logic       alarm_clr;
  logic       mode_12h;

  // time and status, driven by the RTC
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic [4:0] disp_hours;
  logic       pm;
  logic       sec_tick;
  logic       alarm;
  logic       cfg_err;

  modport master (
    output run, load, set_hours, set_minutes, set_seconds,
    output alarm_wr, alarm_hours, alarm_minutes, alarm_en, alarm_clr, mode_12h,
    input  seconds, minutes, hours, disp_hours, pm, sec_tick, alarm, cfg_err
  );

  modport slave (
    input  run, load, set_hours, set_minutes, set_seconds,
    input  alarm_wr, alarm_hours, alarm_minutes, alarm_en, alarm_clr, mode_12h,
    output seconds, minutes, hours, disp_hours, pm, sec_tick, alarm, cfg_err
  );
endinterface

// File: rtl/rtc_alarm.sv
// Real-time clock with internal seconds prescaler, runtime load, hh:mm alarm, 12/24h display.
// Latency: time/flags registered (1 cycle after strobe or tick); disp_hours/pm combinational.
// Backpressure: none; out-of-range load/alarm writes are dropped and flagged on cfg_err.
module rtc_alarm #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  rtc_alarm_if.slave  bus
);

  // a one-tick-per-second prescaler still needs a 1-bit counter to elaborate
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] pre_q;
  logic [5:0]    sec_q;
  logic [5:0]    min_q;
  logic [4:0]    hr_q;
  logic [4:0]    alm_hr_q;
  logic [5:0]    alm_min_q;
  logic          alarm_q;
  logic          tick_q;
  logic          cfg_err_q;

  logic          tick;
  logic          load_ok;
  logic          alm_ok;
  logic          load_acc;
  logic          alm_acc;
  logic          adv;
  logic          alarm_hit;
  logic          sec_wrap;
  logic          min_wrap;
  logic          hr_wrap;
  logic [5:0]    sec_nxt;
  logic [5:0]    min_nxt;
  logic [4:0]    hr_nxt;
  logic [4:0]    disp_hr;

  // strobe validation is independent per strobe so both can be judged in one cycle
  assign load_ok  = (bus.set_hours <= 5'd23) && (bus.set_minutes <= 6'd59) &&
                    (bus.set_seconds <= 6'd59);
  assign alm_ok   = (bus.alarm_hours <= 5'd23) && (bus.alarm_minutes <= 6'd59);
  assign load_acc = bus.load && load_ok;
  assign alm_acc  = bus.alarm_wr && alm_ok;

  // a tick only happens while running; an accepted load swallows it
  assign tick = bus.run && (pre_q == PRE_TC);
  assign adv  = tick && !load_acc;

  // carry chain so 23:59:59 rolls to 00:00:00 in one tick
  assign sec_wrap = (sec_q == 6'd59);
  assign min_wrap = (min_q == 6'd59);
  assign hr_wrap  = (hr_q == 5'd23);

  // next-second value computed combinationally so the alarm can compare against it
  always_comb begin
    sec_nxt = sec_wrap ? 6'd0 : sec_q + 6'd1;
    min_nxt = min_q;
    hr_nxt  = hr_q;
    if (sec_wrap) begin
      min_nxt = min_wrap ? 6'd0 : min_q + 6'd1;
      if (min_wrap) begin
        hr_nxt = hr_wrap ? 5'd0 : hr_q + 5'd1;
      end
    end
  end

  // match on the time being entered, so alarm rises with the matching update
  assign alarm_hit = bus.alarm_en && adv && (hr_nxt == alm_hr_q) &&
                     (min_nxt == alm_min_q) && (sec_nxt == 6'd0);

  // prescaler: counts only while running, restarts the second on an accepted load
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_q <= '0;
    end else if (load_acc) begin
      pre_q <= '0;
    end else if (bus.run) begin
      pre_q <= (pre_q == PRE_TC) ? '0 : pre_q + PW'(1);
    end
  end

  // time registers: load has priority over a coincident tick
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sec_q <= 6'd0;
      min_q <= 6'd0;
      hr_q  <= 5'd0;
    end else if (load_acc) begin
      sec_q <= bus.set_seconds;
      min_q <= bus.set_minutes;
      hr_q  <= bus.set_hours;
    end else if (adv) begin
      sec_q <= sec_nxt;
      min_q <= min_nxt;
      hr_q  <= hr_nxt;
    end
  end

  // stored alarm time, only overwritten by an in-range write
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      alm_hr_q  <= 5'd0;
      alm_min_q <= 6'd0;
    end else if (alm_acc) begin
      alm_hr_q  <= bus.alarm_hours;
      alm_min_q <= bus.alarm_minutes;
    end
  end

  // sticky alarm flag: a new match beats a coincident clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      alarm_q <= 1'b0;
    end else if (alarm_hit) begin
      alarm_q <= 1'b1;
    end else if (bus.alarm_clr) begin
      alarm_q <= 1'b0;
    end
  end

  // single-cycle status pulses: second tick and rejected configuration strobes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      tick_q    <= adv;
      cfg_err_q <= (bus.load && !load_ok) || (bus.alarm_wr && !alm_ok);
    end
  end

  // 12-hour view: midnight shows as 12, afternoon folds down by 12
  always_comb begin
    disp_hr = hr_q;
    if (bus.mode_12h) begin
      if (hr_q == 5'd0) begin
        disp_hr = 5'd12;
      end else if (hr_q > 5'd12) begin
        disp_hr = hr_q - 5'd12;
      end
    end
  end

  assign bus.seconds    = sec_q;
  assign bus.minutes    = min_q;
  assign bus.hours      = hr_q;
  assign bus.disp_hours = disp_hr;
  assign bus.pm         = (hr_q >= 5'd12);
  assign bus.sec_tick   = tick_q;
  assign bus.alarm      = alarm_q;
  assign bus.cfg_err    = cfg_err_q;

endmodule

// File: doc/rtc_alarm.md
# rtc_alarm

Parametrised real-time clock with an on-chip seconds prescaler, runtime time load, a single hour:minute alarm, and 12/24-hour display mode. It is the successor to the team's free-running 1 Hz hours/minutes/seconds counter. It runs directly from the system clock and produces its own one-second tick, so upstream logic no longer needs a 1 Hz clock domain. It sits between the register interface and the display/interrupt logic.

## Interface

Parameters:
- TICKS_PER_SEC, default 50_000_000: system clocks per second. Legal range is 1 or greater. Prescaler width is clog2(TICKS_PER_SEC), minimum 1.

Ports:
- clk, input, 1: system clock. All logic runs on the rising edge.
- reset_n, input, 1: reset. One clock; reset is synchronous and active-low.
- run, input, 1: when 1, the prescaler counts and time advances. When 0, the prescaler and time hold.
- load, input, 1: single-cycle strobe that loads set_* into the time registers.
- set_hours, input, 5: load value, 0–23.
- set_minutes, input, 6: load value, 0–59.
- set_seconds, input, 6: load value, 0–59.
- alarm_wr, input, 1: single-cycle strobe that writes the alarm time.
- alarm_hours, input, 5: alarm value, 0–23.
- alarm_minutes, input, 6: alarm value, 0–59.
- alarm_en, input, 1: arms alarm matching.
- alarm_clr, input, 1: clears the sticky alarm flag.
- mode_12h, input, 1: selects disp_hours format. 1 = 12-hour, 0 = 24-hour.
- seconds, output, 6: current seconds, 0–59.
- minutes, output, 6: current minutes, 0–59.
- hours, output, 5: current hours, 0–23, always in 24-hour format.
- disp_hours, output, 5: display hours, formatted per mode_12h.
- pm, output, 1: 1 when hours is 12 or greater, in both modes.
- sec_tick, output, 1: one-cycle pulse on each time advance.
- alarm, output, 1: sticky alarm flag.
- cfg_err, output, 1: one-cycle pulse when a load or alarm_wr is rejected.

## Operation

**Reset** (reset_n = 0 at a rising edge):
- Time = 00:00:00, prescaler = 0, alarm time = 00:00.
- alarm = 0, sec_tick = 0, cfg_err = 0.
- Reset overrides every other input.

**Prescaler:**
- While run = 1, the prescaler counts 0 to TICKS_PER_SEC−1.
- At terminal count it wraps to 0 and generates an internal tick.
- With TICKS_PER_SEC = 1, a tick occurs every run cycle.

**Time advance on tick:**
- seconds 59 → 0 and minutes increments.
- minutes 59 → 0 and hours increments.
- hours 23 → 0.
- 23:59:59 → 00:00:00 in a single tick.

**Load:**
- Valid only if set_hours ≤ 23, set_minutes ≤ 59 and set_seconds ≤ 59.
- Valid load: time takes the set values and the prescaler clears to 0. Load wins over a coincident tick, so no increment occurs and sec_tick stays 0 that cycle.
- A load is accepted even when run = 0.
- Invalid load: time and prescaler are unchanged and cfg_err pulses.

**alarm_wr:**
- Valid only if alarm_hours ≤ 23 and alarm_minutes ≤ 59.
- Valid write stores the alarm time. Invalid write is ignored and cfg_err pulses.
- load and alarm_wr may occur in the same cycle. Each is validated independently, and cfg_err is the OR of the two rejections.

**Alarm match:**
- alarm is set when all of the following hold in the same cycle:
  - alarm_en = 1;
  - a tick advances time;
  - the new time equals alarm_hours:alarm_minutes:00 (stored values).
- A load never triggers the alarm, even if the loaded time matches.
- alarm stays 1 until alarm_clr = 1. If set and clear coincide, set wins.
- Clearing alarm_en does not clear a pending alarm.

**Display:**
- mode_12h = 0: disp_hours = hours.
- mode_12h = 1: hours 0 → 12; hours 1–12 → unchanged; hours 13–23 → hours−12.
- disp_hours and pm are combinational from the hours register and mode_12h.

## Timing

- All outputs except disp_hours and pm are registered.
- A tick edge updates time and asserts sec_tick in the same cycle. sec_tick deasserts on the next edge unless another tick occurs.
- With run held at 1, sec_tick period = TICKS_PER_SEC cycles.
- Load latency: one cycle; the new values are visible after the load edge. The first tick after a valid load comes TICKS_PER_SEC run cycles later.
- Alarm latency: alarm rises on the same edge as the matching time update.
- cfg_err is registered: high for exactly the cycle after the rejected strobe edge.
- Deasserting run mid-count freezes the prescaler. Reasserting it resumes from the frozen value, with no lost or extra tick.
- Asserting reset_n = 0 mid-second discards the partial prescaler count.

## Test plan

Run with TICKS_PER_SEC = 4.
1. Reset, then run = 1 for 12 cycles → sec_tick pulses on cycles 4, 8 and 12; seconds = 3; minutes = 0; hours = 0.
2. Load 23:59:58, run 8 cycles → 23:59:59 then 00:00:00; pm goes 1 → 0; disp_hours goes 11 → 12 with mode_12h = 1.
3. Load with set_minutes = 60 → time unchanged; cfg_err high for one cycle. Then alarm_wr with alarm_hours = 24 → alarm time unchanged; cfg_err pulses.
4. Alarm 01:00, alarm_en = 1, load 00:59:59 → alarm rises on the next tick. Then alarm_clr coincident with no match → alarm = 0. Reloading 01:00:00 directly → alarm stays 0.
5. load asserted on the exact terminal-count cycle → loaded value is kept, no increment, sec_tick = 0; next sec_tick follows 4 cycles later.
6. run = 0 for 10 cycles at prescaler = 2 → time frozen, no sec_tick. Resume → first tick after 2 run cycles. reset_n = 0 mid-second → all outputs return to their reset values on the next edge.
